// File: rtl/mac_ctrl_pkg.sv
// Shared sizes, row map and state encoding for the MAC/FIFO sequencer.
package mac_ctrl_pkg;

   localparam int unsigned ROWS   = 8;
   localparam int unsigned DW     = 8;
   localparam int unsigned ACC_W  = 24;
   localparam int unsigned MEM_DW = 64;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned ROW_W  = 4;
   localparam int unsigned K_W    = 3;

   localparam logic [ROW_W-1:0] B_ADDR = ROW_W'(0);
   localparam logic [ROW_W-1:0] A_BASE = ROW_W'(1);
   localparam logic [ROW_W-1:0] A_LAST = A_BASE + ROW_W'(ROWS - 1);
   localparam logic [K_W-1:0]   K_LAST = K_W'(ROWS - 1);

   typedef enum logic [2:0] {
      IDLE, CLR, RD_REQ, RD_WAIT, PUSH, EXEC, DRAIN, DONE
   } state_t;

   // Byte i of a memory row, byte 0 in the low bits.
   function automatic logic [DW-1:0] row_byte(input logic [MEM_DW-1:0] r,
                                              input logic [K_W-1:0]    i);
      return r[i*DW +: DW];
   endfunction

endpackage

// File: rtl/mem_row_reader.sv
// Avalon-style single-outstanding row read: request/accept handshake plus row latch.
module mem_row_reader
   import mac_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [ROW_W-1:0]  addr,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   input  logic [MEM_DW-1:0] mem_readdata,
   input  logic              mem_readdatavalid,
   input  logic              mem_waitrequest,
   output logic              accept_c,
   output logic              row_valid_c,
   output logic [MEM_DW-1:0] row_data
);

   logic pending;

   assign accept_c    = mem_read & ~mem_waitrequest;
   // Data beats are only meaningful while an accepted read is outstanding.
   assign row_valid_c = pending & mem_readdatavalid;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_read    <= 1'b0;
         mem_address <= '0;
         pending     <= 1'b0;
         row_data    <= '0;
      end else begin
         if (req) begin
            mem_read    <= 1'b1;
            mem_address <= ADDR_W'(addr);
         end else if (accept_c) begin
            mem_read <= 1'b0;
            pending  <= 1'b1;
         end
         if (row_valid_c) begin
            pending  <= 1'b0;
            row_data <= mem_readdata;
         end
      end
   end

endmodule

// File: rtl/mac_fifo_ctrl.sv
// Sequencer: fetch B and eight A rows, load per-row FIFOs, stream FIFOs against B
// into the MACs and capture the dot products.
module mac_fifo_ctrl
   import mac_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic [ADDR_W-1:0]     mem_address,
   output logic                  mem_read,
   input  logic [MEM_DW-1:0]     mem_readdata,
   input  logic                  mem_readdatavalid,
   input  logic                  mem_waitrequest,
   output logic [DW-1:0]         fifo_wdata,
   output logic [ROWS-1:0]       fifo_wren,
   input  logic [ROWS-1:0]       fifo_full,
   output logic                  fifo_rden,
   input  logic [ROWS-1:0]       fifo_empty,
   output logic [DW-1:0]         b_data,
   output logic                  mac_en,
   output logic                  mac_clr,
   input  logic [ROWS*ACC_W-1:0] mac_cout,
   output logic [ROWS*ACC_W-1:0] result,
   output logic                  busy,
   output logic                  done
);

   state_t            state;
   logic [ROW_W-1:0]  row;
   logic [K_W-1:0]    byte_idx;
   logic [K_W-1:0]    k;
   logic              drain_cnt;
   logic [MEM_DW-1:0] b_reg;

   logic              rd_req_c;
   logic [ROW_W-1:0]  rd_addr_c;
   logic [K_W-1:0]    a_idx_c;
   logic              accept_c;
   logic              row_valid_c;
   logic [MEM_DW-1:0] row_data;

   mem_row_reader u_reader (
      .clk               (clk),
      .rst               (rst),
      .req               (rd_req_c),
      .addr              (rd_addr_c),
      .mem_address       (mem_address),
      .mem_read          (mem_read),
      .mem_readdata      (mem_readdata),
      .mem_readdatavalid (mem_readdatavalid),
      .mem_waitrequest   (mem_waitrequest),
      .accept_c          (accept_c),
      .row_valid_c       (row_valid_c),
      .row_data          (row_data)
   );

   // FIFO strobes follow full/empty in the same cycle so a stalled FIFO never sees a stray strobe.
   always_comb begin
      rd_req_c   = 1'b0;
      rd_addr_c  = row;
      a_idx_c    = K_W'(row - A_BASE);
      fifo_wren  = '0;
      fifo_wdata = '0;
      fifo_rden  = 1'b0;
      case (state)
         CLR: begin
            rd_req_c  = 1'b1;
            rd_addr_c = B_ADDR;
         end
         RD_WAIT: begin
            if (row_valid_c && row == B_ADDR) begin
               rd_req_c  = 1'b1;
               rd_addr_c = A_BASE;
            end
         end
         PUSH: begin
            if (!fifo_full[a_idx_c]) begin
               fifo_wren  = ROWS'(1) << a_idx_c;
               fifo_wdata = row_byte(row_data, byte_idx);
               if (byte_idx == K_LAST && row != A_LAST) begin
                  rd_req_c  = 1'b1;
                  rd_addr_c = row + ROW_W'(1);
               end
            end
         end
         EXEC: fifo_rden = (fifo_empty == '0);
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         row       <= '0;
         byte_idx  <= '0;
         k         <= '0;
         drain_cnt <= 1'b0;
         b_reg     <= '0;
         mac_clr   <= 1'b0;
         mac_en    <= 1'b0;
         b_data    <= '0;
         result    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         mac_clr <= 1'b0;
         // One-cycle FIFO read latency: MAC enable and B byte trail the read by a cycle.
         mac_en  <= fifo_rden;
         b_data  <= fifo_rden ? row_byte(b_reg, k) : '0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state   <= CLR;
                  mac_clr <= 1'b1;
                  busy    <= 1'b1;
                  done    <= 1'b0;
               end
            end
            CLR: begin
               row   <= B_ADDR;
               state <= RD_REQ;
            end
            RD_REQ: begin
               // The reader still holds B while the first A row is being requested.
               if (row == A_BASE) b_reg <= row_data;
               if (accept_c) state <= RD_WAIT;
            end
            RD_WAIT: begin
               if (row_valid_c) begin
                  if (row == B_ADDR) begin
                     row   <= A_BASE;
                     state <= RD_REQ;
                  end else begin
                     byte_idx <= '0;
                     state    <= PUSH;
                  end
               end
            end
            PUSH: begin
               if (!fifo_full[a_idx_c]) begin
                  byte_idx <= byte_idx + K_W'(1);
                  if (byte_idx == K_LAST) begin
                     if (row == A_LAST) begin
                        k     <= '0;
                        state <= EXEC;
                     end else begin
                        row   <= row + ROW_W'(1);
                        state <= RD_REQ;
                     end
                  end
               end
            end
            EXEC: begin
               if (fifo_rden) begin
                  k <= k + K_W'(1);
                  if (k == K_LAST) begin
                     drain_cnt <= 1'b0;
                     state     <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (!drain_cnt) begin
                  drain_cnt <= 1'b1;
               end else begin
                  result <= mac_cout;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_fifo_ctrl.sv
// Bench for mac_fifo_ctrl with behavioural memory, FIFO and MAC models around the DUT.
module tb_mac_fifo_ctrl;
   import mac_ctrl_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start;
   logic [31:0]  mem_address;
   logic         mem_read, mem_readdatavalid, mem_waitrequest;
   logic [63:0]  mem_readdata;
   logic [7:0]   fifo_wdata, fifo_wren, fifo_full, fifo_empty;
   logic         fifo_rden;
   logic [7:0]   b_data;
   logic         mac_en, mac_clr, busy, done;
   logic [191:0] mac_cout, result;

   mac_fifo_ctrl dut (
      .clk(clk), .rst(rst), .start(start),
      .mem_address(mem_address), .mem_read(mem_read), .mem_readdata(mem_readdata),
      .mem_readdatavalid(mem_readdatavalid), .mem_waitrequest(mem_waitrequest),
      .fifo_wdata(fifo_wdata), .fifo_wren(fifo_wren), .fifo_full(fifo_full),
      .fifo_rden(fifo_rden), .fifo_empty(fifo_empty), .b_data(b_data),
      .mac_en(mac_en), .mac_clr(mac_clr), .mac_cout(mac_cout), .result(result),
      .busy(busy), .done(done)
   );

   int total = 0;
   int bad   = 0;

   // Environment models
   logic [63:0] mem [0:15];
   int          wait_left, lat_n, full_left, empty_left;
   logic        rd_pend;
   int          rd_cnt;
   logic [3:0]  rd_addr;
   logic [7:0]  fq [8][32];
   logic [4:0]  wp [8];
   logic [4:0]  rp [8];
   logic [7:0]  fout [8];
   logic [23:0] acc [8];

   assign mem_waitrequest = mem_read && (mem_address == 32'd2) && (wait_left != 0);

   for (genvar g = 0; g < 8; g++) begin : g_cout
      assign mac_cout[g*24 +: 24] = acc[g];
   end

   always_comb begin
      for (int r = 0; r < 8; r++) begin
         fifo_empty[r] = (wp[r] == rp[r]);
         fifo_full[r]  = 1'b0;
      end
      if (full_left != 0 && wp[3] == 5'd2) fifo_full[3] = 1'b1;
      if (empty_left != 0 && rp[5] == 5'd3) fifo_empty[5] = 1'b1;
   end

   always @(posedge clk) begin
      mem_readdatavalid <= 1'b0;
      if (rst) begin
         rd_pend      <= 1'b0;
         mem_readdata <= '0;
         for (int r = 0; r < 8; r++) begin
            wp[r] <= '0; rp[r] <= '0; fout[r] <= '0; acc[r] <= '0;
         end
      end else begin
         if (mem_waitrequest) wait_left <= wait_left - 1;
         if (mem_read && !mem_waitrequest) begin
            rd_addr <= mem_address[3:0];
            if (lat_n <= 1) begin
               mem_readdatavalid <= 1'b1;
               mem_readdata      <= mem[mem_address[3:0]];
            end else begin
               rd_pend <= 1'b1;
               rd_cnt  <= lat_n - 1;
            end
         end
         if (rd_pend) begin
            if (rd_cnt == 1) begin
               mem_readdatavalid <= 1'b1;
               mem_readdata      <= mem[rd_addr];
               rd_pend           <= 1'b0;
            end else rd_cnt <= rd_cnt - 1;
         end
         if (fifo_full[3]) full_left <= full_left - 1;
         if (empty_left != 0 && rp[5] == 5'd3) empty_left <= empty_left - 1;
         for (int r = 0; r < 8; r++) begin
            if (fifo_wren[r]) begin
               fq[r][wp[r]] <= fifo_wdata;
               wp[r]        <= wp[r] + 5'd1;
            end
            if (fifo_rden) begin
               fout[r] <= fq[r][rp[r]];
               rp[r]   <= rp[r] + 5'd1;
            end
            if (mac_en) acc[r] <= acc[r] + 24'(fout[r]) * 24'(b_data);
            if (mac_clr) begin
               acc[r] <= '0; wp[r] <= '0; rp[r] <= '0;
            end
         end
      end
   end

   // Protocol monitors
   int          n_clr, n_en, n_rden, n_stall, v_wren, v_rden, v_hold;
   logic        prev_wait;
   logic [31:0] prev_addr;

   always @(posedge clk) begin
      prev_wait <= mem_waitrequest;
      prev_addr <= mem_address;
      if (mac_clr) n_clr <= n_clr + 1;
      if (mac_en) n_en <= n_en + 1;
      if (fifo_rden) n_rden <= n_rden + 1;
      if (mem_waitrequest && mem_address == 32'd2) n_stall <= n_stall + 1;
      if ((fifo_wren & fifo_full) != 8'd0) v_wren <= v_wren + 1;
      if (fifo_rden && fifo_empty != 8'd0) v_rden <= v_rden + 1;
      if (prev_wait && (!mem_read || mem_address != prev_addr)) v_hold <= v_hold + 1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      int          pat;
      int          wait_c;
      int          lat;
      int          full_c;
      int          empty_c;
      logic [23:0] exp_mul;
      logic [23:0] exp_add;
   } vec_t;

   vec_t vecs [5];

   // pat 0: B=1, A row r = r+1; pat 1: all 0xFF; pat 2: B byte k = k+1, A row r byte k = 8r+k
   task automatic fill_mem(input int pat);
      int v;
      for (int r = 0; r < 16; r++) mem[r] = '0;
      for (int r = 0; r < 9; r++)
         for (int kk = 0; kk < 8; kk++) begin
            case (pat)
               0:       v = (r == 0) ? 1 : r;
               1:       v = 255;
               default: v = (r == 0) ? kk + 1 : 8 * (r - 1) + kk;
            endcase
            mem[r][kk*8 +: 8] = 8'(v);
         end
   endtask

   task automatic clear_mon();
      n_clr = 0; n_en = 0; n_rden = 0; n_stall = 0;
      v_wren = 0; v_rden = 0; v_hold = 0;
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({name, " done"}, 64'(done), 64'(1));
   endtask

   task automatic check_results(input string name, input logic [23:0] mul, input logic [23:0] add);
      for (int r = 0; r < 8; r++)
         check($sformatf("%s res%0d", name, r), 64'(result[r*24 +: 24]), 64'(mul * 24'(r) + add));
   endtask

   task automatic run_vec(input int i);
      string nm;
      logic [63:0] got;
      nm = $sformatf("v%0d", i);
      fill_mem(vecs[i].pat);
      wait_left = vecs[i].wait_c; lat_n = vecs[i].lat;
      full_left = vecs[i].full_c; empty_left = vecs[i].empty_c;
      clear_mon();
      pulse_start();
      check({nm, " busy"}, 64'({busy, done}), 64'(2'b10));
      wait_done(nm);
      repeat (2) @(negedge clk);
      check_results(nm, vecs[i].exp_mul, vecs[i].exp_add);
      check({nm, " busy_end"}, 64'({busy, done}), 64'(2'b01));
      check({nm, " n_clr"}, 64'(n_clr), 64'(1));
      check({nm, " n_en"}, 64'(n_en), 64'(8));
      check({nm, " n_rden"}, 64'(n_rden), 64'(8));
      check({nm, " wren_full"}, 64'(v_wren), 64'(0));
      check({nm, " rden_empty"}, 64'(v_rden), 64'(0));
      check({nm, " req_hold"}, 64'(v_hold), 64'(0));
      check({nm, " stall_cyc"}, 64'(n_stall), 64'(vecs[i].wait_c));
      for (int kk = 0; kk < 8; kk++) got[kk*8 +: 8] = fq[3][kk];
      check({nm, " fifo3_order"}, got, mem[4]);
   endtask

   initial begin
      int n;
      vecs[0] = '{0, 0, 1, 0, 0, 24'd8,   24'd8};
      vecs[1] = '{1, 0, 1, 0, 0, 24'd0,   24'd520200};
      vecs[2] = '{0, 3, 4, 0, 0, 24'd8,   24'd8};
      vecs[3] = '{2, 0, 1, 5, 3, 24'd288, 24'd168};
      vecs[4] = '{2, 2, 2, 0, 0, 24'd288, 24'd168};

      rst = 1'b1; start = 1'b0;
      wait_left = 0; lat_n = 1; full_left = 0; empty_left = 0;
      clear_mon();
      repeat (3) @(negedge clk);
      check("reset outs", {mem_address, fifo_wren, fifo_wdata, b_data, mem_read, fifo_rden,
                           mac_en, mac_clr, busy, done}, 64'(0));
      check("reset result", 64'(|result), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      check("idle", 64'({busy, done, mem_read}), 64'(0));

      for (int i = 0; i < 5; i++) run_vec(i);

      // Reset in the middle of the row-4 PUSH
      fill_mem(0);
      wait_left = 0; lat_n = 1; full_left = 0; empty_left = 0;
      pulse_start();
      n = 0;
      while (!fifo_wren[3] && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("row4 push seen", 64'(fifo_wren[3]), 64'(1));
      rst = 1'b1;
      @(negedge clk);
      check("midrst outs", {mem_address, fifo_wren, fifo_wdata, b_data, mem_read, fifo_rden,
                            mac_en, mac_clr, busy, done}, 64'(0));
      check("midrst result", 64'(|result), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      run_vec(0);

      // start during EXEC is ignored
      fill_mem(2);
      clear_mon();
      pulse_start();
      n = 0;
      while (!fifo_rden && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("exec seen", 64'(fifo_rden), 64'(1));
      pulse_start();
      wait_done("exec_start");
      repeat (4) @(negedge clk);
      check("exec_start n_clr", 64'(n_clr), 64'(1));
      check("exec_start n_en", 64'(n_en), 64'(8));
      check("exec_start done", 64'({busy, done}), 64'(2'b01));
      check_results("exec_start", 24'd288, 24'd168);

      // Restart from DONE replaces the old results
      run_vec(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
